// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: opcodes, ALU operation codes and multicycle FSM states.
// Intended for reuse by later cores in this family.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  // funct7[5] selects sub only for register-register ops; addi has no sub form.
  function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32 integer ALU; shifts use b[4:0] and arithmetic wraps mod 2^32.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_core.sv
// Multicycle RV32I/E subset core: FETCH/DECODE/EXEC/MEM/WB with a single shared memory port.
// Any illegal, unsupported or misaligned instruction parks the core in HALT until reset.
module rv32_multicycle_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int         RAW  = $clog2(NUM_REGS);
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  state_t      state, state_n;
  logic [31:0] ir, imm, imm_d, rs1_v, rs2_v, alu_q, alu_b, alu_y;
  logic [31:0] regs [NUM_REGS];
  logic        take_br, legal, reg_ok, uses_rs1, uses_rs2, uses_rd, is_mem;
  alu_op_t     alu_op;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign is_mem = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

  always_comb begin
    legal = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0; uses_rd = 1'b0; imm_d = '0;
    case (opcode)
      OPC_OP: begin
        legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
      end
      OPC_OPIMM: begin
        legal = (f3 != 3'b001 && f3 != 3'b101) || (f7 == 7'b0) ||
                (f3 == 3'b101 && f7 == 7'b0100000);
        uses_rs1 = 1'b1; uses_rd = 1'b1;
        imm_d = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_LOAD: begin
        legal = (f3 == 3'b010); uses_rs1 = 1'b1; uses_rd = 1'b1;
        imm_d = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: begin
        legal = (f3 == 3'b010); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_BRANCH: begin
        legal = (f3 == 3'b000 || f3 == 3'b001); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm_d = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_JAL: begin
        legal = 1'b1; uses_rd = 1'b1;
        imm_d = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      default: ;
    endcase
    // RV32E builds reject any referenced register index beyond the file.
    reg_ok = (!uses_rs1 || {1'b0, rs1} < NREG) && (!uses_rs2 || {1'b0, rs2} < NREG) &&
             (!uses_rd || {1'b0, rd} < NREG);
  end

  assign alu_b  = (opcode == OPC_OP) ? rs2_v : imm;
  assign alu_op = (opcode == OPC_OP || opcode == OPC_OPIMM) ?
                  alu_op_decode(f3, f7[5], opcode == OPC_OP) : ALU_ADD;

  rv32_alu u_alu (.a(rs1_v), .b(alu_b), .op(alu_op), .y(alu_y));

  // Memory handshake: the core raises mem_req with we/addr/wdata and holds all of
  // them unchanged until it samples mem_ready=1 on a rising edge; that edge completes
  // the transfer and mem_req drops in the following cycle. Reset forces the port idle.
  always_comb begin
    state_n = state; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1; mem_addr = pc;
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: state_n = (legal && reg_ok) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_mem) state_n = (alu_y[1:0] != 2'b00) ? S_HALT : S_MEM;
        else        state_n = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1; mem_we = (opcode == OPC_STORE); mem_addr = alu_q; mem_wdata = rs2_v;
        if (mem_ready) state_n = S_WB;
      end
      S_WB:    state_n = S_FETCH;
      default: state_n = S_HALT;
    endcase
    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    end
  end

  assign halted = (state == S_HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH; pc <= RESET_PC; ir <= '0; imm <= '0;
      rs1_v <= '0; rs2_v <= '0; alu_q <= '0; take_br <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_FETCH: if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          rs1_v <= regs[rs1[RAW-1:0]];
          rs2_v <= regs[rs2[RAW-1:0]];
          imm   <= imm_d;
        end
        S_EXEC: begin
          alu_q   <= alu_y;
          take_br <= (rs1_v == rs2_v) ^ f3[0];
        end
        S_MEM: if (mem_ready && opcode == OPC_LOAD) alu_q <= mem_rdata;
        S_WB: begin
          if (uses_rd && rd != 5'd0)
            regs[rd[RAW-1:0]] <= (opcode == OPC_JAL) ? pc + 32'd4 : alu_q;
          pc <= (opcode == OPC_JAL || (opcode == OPC_BRANCH && take_br)) ? pc + imm : pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core: program images in a word memory, a scoreboard
// of expected memory transfers, and latency/register/halt checks after each instruction.
module tb_rv32_multicycle_core;

  logic        clk, rst, mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  rv32_multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .pc(pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: {wait[7:0], we, addr[31:0], wdata[31:0]}
  logic [72:0] exp_q[$];
  logic [72:0] cur;
  logic [31:0] mem [0:255];
  logic [31:0] held_addr, held_wdata;
  logic        held_we, in_xfer;
  int          wait_cnt, n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wt);
    exp_q.push_back({8'(wt), we, addr, wdata});
  endtask

  // memory responder: drives ready/rdata after the main process has sampled on negedge
  always @(negedge clk) begin
    #2;
    if (mem_req) begin
      if (!in_xfer) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $error("FAIL unexpected_req: observed addr %h expected no request", mem_addr);
        end else begin
          cur = exp_q[0]; in_xfer = 1'b1; wait_cnt = 0;
          check("xfer_we", {31'b0, mem_we}, {31'b0, cur[64]});
          check("xfer_addr", mem_addr, cur[63:32]);
          if (cur[64]) check("xfer_wdata", mem_wdata, cur[31:0]);
          held_addr = mem_addr; held_we = mem_we; held_wdata = mem_wdata;
        end
      end else begin
        check("stall_addr", mem_addr, held_addr);
        check("stall_we", {31'b0, mem_we}, {31'b0, held_we});
        if (held_we) check("stall_wdata", mem_wdata, held_wdata);
      end
      mem_ready = 1'b0;
      if (in_xfer) begin
        if (wait_cnt < int'(cur[72:65])) begin
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          void'(exp_q.pop_front());
          in_xfer = 1'b0;
        end
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // driver tasks
  task automatic step(input string tag, input int exp_cyc);
    logic [31:0] pc0;
    int n;
    pc0 = pc; n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (pc === pc0 && !halted && n < 60);
    check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); in_xfer = 1'b0; wait_cnt = 0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
    check("first_req", {31'b0, mem_req}, 32'd1);
  endtask

  task automatic expect_halt_hold(input string tag, input logic [31:0] exp_pc);
    check({tag, "_halted"}, {31'b0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_no_req"}, {31'b0, mem_req}, 32'd0);
    end
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  int w;
  logic [31:0] x4_exp;

  initial begin
    n_checks = 0; n_pass = 0; in_xfer = 1'b0; wait_cnt = 0;
    mem_ready = 1'b0; mem_rdata = '0; rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // run 1: ALU, stalled fetch, store/load, branch, jal, RV32E register limit
    mem[0]  = 32'h00500093;  // addi x1,x0,5
    mem[1]  = 32'h10000113;  // addi x2,x0,0x100
    mem[2]  = 32'h00112423;  // sw   x1,8(x2)
    mem[3]  = 32'h00812183;  // lw   x3,8(x2)
    mem[4]  = 32'h40208233;  // sub  x4,x1,x2
    mem[5]  = 32'h40425293;  // srai x5,x4,4
    mem[6]  = 32'h0040B333;  // sltu x6,x1,x4
    mem[7]  = 32'h00700013;  // addi x0,x0,7
    mem[8]  = 32'h00000863;  // beq  x0,x0,+16
    mem[12] = 32'h008003EF;  // jal  x7,+8
    mem[14] = 32'h00208A33;  // add  x20,x1,x2
    push_xfer(0, 32'h00, 0, 0);  push_xfer(0, 32'h04, 0, 3);
    push_xfer(0, 32'h08, 0, 0);  push_xfer(1, 32'h108, 32'd5, 0);
    push_xfer(0, 32'h0C, 0, 0);  push_xfer(0, 32'h108, 0, 0);
    push_xfer(0, 32'h10, 0, 0);  push_xfer(0, 32'h14, 0, 0);
    push_xfer(0, 32'h18, 0, 0);  push_xfer(0, 32'h1C, 0, 0);
    push_xfer(0, 32'h20, 0, 0);  push_xfer(0, 32'h30, 0, 0);
    push_xfer(0, 32'h38, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_ir", dut.ir, 32'h0);
    release_reset();

    step("addi", 4);           check("addi_x1", dut.regs[1], 32'd5); check("addi_pc", pc, 32'h4);
    step("addi_stall", 7);     check("addi_x2", dut.regs[2], 32'h100);
    step("sw", 5);             check("sw_mem", mem[32'h108 >> 2], 32'd5);
    step("lw", 5);             check("lw_x3", dut.regs[3], 32'd5);
    x4_exp = 32'd5 - 32'h100;
    step("sub", 4);            check("sub_x4", dut.regs[4], x4_exp);
    step("srai", 4);           check("srai_x5", dut.regs[5], 32'($signed(x4_exp) >>> 4));
    step("sltu", 4);           check("sltu_x6", dut.regs[6], 32'(32'd5 < x4_exp));
    step("addi_x0", 4);        check("x0_zero", dut.regs[0], 32'h0);
    step("beq", 4);            check("beq_pc", pc, 32'h30);
    step("jal", 4);            check("jal_pc", pc, 32'h38); check("jal_x7", dut.regs[7], 32'h34);
    step("rv32e_halt", 2);
    expect_halt_hold("rv32e", 32'h38);

    // run 2: regfile cleared by reset, stalled jal fetch, bne not taken, misaligned lw
    do_reset();
    check("rst2_x1", dut.regs[1], 32'h0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_halted", {31'b0, halted}, 32'd0);
    mem[0] = 32'h0200006F;  // jal x0,+32
    mem[8] = 32'h00001863;  // bne x0,x0,+16
    mem[9] = 32'h00102183;  // lw  x3,1(x0)
    w = $urandom_range(0, 2);
    push_xfer(0, 32'h00, 0, w); push_xfer(0, 32'h20, 0, 0); push_xfer(0, 32'h24, 0, 0);
    release_reset();
    step("jal_wait", 4 + w);   check("jal2_pc", pc, 32'h20);
    step("bne", 4);            check("bne_pc", pc, 32'h24);
    step("misaligned", 3);
    expect_halt_hold("misaligned", 32'h24);
    check("misaligned_x3", dut.regs[3], 32'h0);

    // run 3: reset during a stalled data read abandons the transfer
    do_reset();
    mem[0] = 32'h04002183;  // lw x3,64(x0)
    push_xfer(0, 32'h00, 0, 0); push_xfer(0, 32'h40, 0, 200);
    release_reset();
    repeat (4) @(negedge clk);
    check("mem_stall_req", {31'b0, mem_req}, 32'd1);
    check("mem_stall_addr", mem_addr, 32'h40);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete(); in_xfer = 1'b0; wait_cnt = 0;
    check("abort_req", {31'b0, mem_req}, 32'd0);
    check("abort_pc", pc, 32'h0);
    check("abort_x3", dut.regs[3], 32'h0);

    // run 4: ecall, then an all-zero instruction
    mem[0] = 32'h00000073;
    push_xfer(0, 32'h00, 0, 0);
    release_reset();
    step("ecall", 2);
    expect_halt_hold("ecall", 32'h0);
    do_reset();
    mem[0] = 32'h0;
    push_xfer(0, 32'h00, 0, 1);
    release_reset();
    step("zero_insn", 3);
    expect_halt_hold("zero_insn", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
